pipelined_carry_select_adder: RTL and testbench
===============================================

Name: pipelined_carry_select_adder

Overview:
- Parametrised, pipelined successor to the 4-bit carry select adder: WIDTH-bit add split into BLOCK-bit carry-select segments.
- Each segment occupies one register stage, with a valid/ready handshake and full back-pressure.
- Serves as the team's reusable adder datapath element where throughput of one add per clock is needed at high frequency.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be an integer multiple of BLOCK.
- BLOCK, 4, bits per carry-select segment; NBLK = WIDTH/BLOCK = pipeline depth.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b/cin are valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry in.
- out_valid  output  1  sum/carry are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- carry  output  1  bit WIDTH of a + b + cin.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst).
- Reset (rst high at an edge): all stage valid bits cleared; sum = 0, carry = 0, out_valid = 0. rst overrides in_valid.
- Global advance: adv = out_ready | ~out_valid. in_ready = adv, which is combinational and independent of in_valid.
- Transfer at input: in_valid & in_ready. Transfer at output: out_valid & out_ready.
- When adv = 0, every stage register and its valid bit hold.
- A stalled output keeps sum and carry stable until it is accepted.
- Stage k (k = 0..NBLK-1):
  - Computes segment k, bits [k*BLOCK +: BLOCK].
  - Forms s0 = A_k + B_k + 0 and s1 = A_k + B_k + 1, each BLOCK+1 bits.
  - Selects between them with the carry registered from stage k-1; stage 0 uses cin.
  - Registers the selected segment sum, the selected carry, and the delayed upper operand segments.
- Operand skew: upper segments of a and b travel with the transaction unmodified until their own stage is reached.
- Latency: result for a transaction accepted at edge N appears with out_valid = 1 after edge N+NBLK-1, i.e. NBLK cycles, provided adv stayed high.
- Throughput: one transaction per cycle when out_ready is held high. Transaction order is preserved.
- Bubbles (in_valid = 0 while adv = 1) propagate as valid = 0. Bubbles are not collapsed.
- Wrap-around: sum is modulo 2^WIDTH. carry = 1 exactly when a + b + cin >= 2^WIDTH.
- Example: a = all-ones, b = 0, cin = 1 gives sum = 0, carry = 1.
- Degenerate case WIDTH = BLOCK: single stage, latency 1.
- Reset mid-operation: all in-flight transactions are discarded. out_valid is 0 on the cycle after the reset edge, and nothing partial is ever emitted.
- Simultaneous transfers: input accept and output accept in the same cycle are legal; the pipeline shifts by one.
- Elaboration check: WIDTH % BLOCK != 0 or BLOCK < 1 triggers $error.

Optional Feature:
- Macro: CSA_OVERFLOW_FLAG_EN.
- Defined: extra output port overflow (output, 1 bit), the two's-complement signed overflow of a + b + cin.
  - overflow = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]).
  - The final stage computes it from the registered MSBs. It is aligned with sum, held under stall, and reset to 0.
- Not defined: the port does not exist, with no extra logic; all other behaviour is identical.

Test Plan (WIDTH = 16, BLOCK = 4, latency 4):
- Reset: rst high 2 cycles with in_valid = 1 -> out_valid = 0, sum = 0000, carry = 0 throughout and on the first cycle after release.
- Single add: a = FFFF, b = 0001, cin = 0, out_ready = 1 -> 4 cycles later out_valid = 1, sum = 0000, carry = 1; next cycle out_valid = 0.
- Carry-in path: a = 1234, b = 4321, cin = 1 -> sum = 5556, carry = 0. Also a = 0FFF, b = 0000, cin = 1 -> sum = 1000, carry = 0, exercising the carry chain through all stages.
- Back-pressure: issue 3 back-to-back vectors (0001+0001, 00FF+0001, 8000+8000) while out_ready is dropped for 2 cycles after the first result.
  - in_ready = 0 during the stall; the held result stays stable.
  - Results arrive in order: 0002/c0, 0100/c0, 0000/c1.
- Reset mid-flight: 2 transactions accepted, then rst pulsed for 1 cycle -> no result ever emitted; a subsequent add completes with correct latency.
- CSA_OVERFLOW_FLAG_EN defined: a = 7FFF, b = 0001, cin = 0 -> sum = 8000, overflow = 1. a = FFFF, b = 0001 -> overflow = 0.
  - Also run 1000 random vectors with random out_ready against a behavioural a + b + cin model.

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder: WIDTH-bit add split into BLOCK-bit segments,
// one segment per register stage, NBLK = WIDTH/BLOCK stages deep.
// Every stage advances together (global stall), so results keep their order.
// Optional feature: define CSA_OVERFLOW_FLAG_EN to add the 'overflow' output
// (two's-complement signed overflow of a + b + cin, aligned with sum).
//
// Handshake: a transfer happens on an edge where valid & ready are both high.
// Producers hold their payload stable while valid is high and ready is low;
// in_ready = out_ready | ~out_valid is combinational and ignores in_valid.
module pipelined_carry_select_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef CSA_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("pipelined_carry_select_adder: WIDTH must be a positive multiple of BLOCK");
  end

  localparam int NBLK = WIDTH / BLOCK;

  // Whole pipeline moves when the output slot is empty or being drained.
  logic adv;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    // REM: operand bits still to be added at this stage (this segment + above).
    // SW : sum bits known once this stage has registered its result.
    localparam int REM = WIDTH - k * BLOCK;
    localparam int SW  = (k + 1) * BLOCK;

    logic [REM-1:0] a_i;
    logic [REM-1:0] b_i;
    logic           c_i;
    logic           v_i;
    logic [BLOCK:0] s0;
    logic [BLOCK:0] s1;
    logic [BLOCK:0] sel;
    logic [SW-1:0]  s_n;
    logic           v_q;
    logic           c_q;
    logic [SW-1:0]  s_q;

    if (k == 0) begin : g_head
      assign a_i = a;
      assign b_i = b;
      assign c_i = cin;
      assign v_i = in_valid;
      assign s_n = sel[BLOCK-1:0];
    end else begin : g_body
      assign a_i = g_stage[k-1].g_fwd.a_q;
      assign b_i = g_stage[k-1].g_fwd.b_q;
      assign c_i = g_stage[k-1].c_q;
      assign v_i = g_stage[k-1].v_q;
      assign s_n = {sel[BLOCK-1:0], g_stage[k-1].s_q};
    end

    // Both candidate segment sums are formed up front; the incoming carry
    // only drives the final select.
    assign s0  = {1'b0, a_i[BLOCK-1:0]} + {1'b0, b_i[BLOCK-1:0]};
    assign s1  = {1'b0, a_i[BLOCK-1:0]} + {1'b0, b_i[BLOCK-1:0]} + {{BLOCK{1'b0}}, 1'b1};
    assign sel = c_i ? s1 : s0;

    // Stage result register: valid bit, selected carry and partial sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_i;
        c_q <= sel[BLOCK];
        s_q <= s_n;
      end
    end

    if (REM > BLOCK) begin : g_fwd
      logic [REM-BLOCK-1:0] a_q;
      logic [REM-BLOCK-1:0] b_q;

      // Skew register: upper operand segments ride along untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_i[REM-1:BLOCK];
          b_q <= b_i[REM-1:BLOCK];
        end
      end
    end
  end

  assign out_valid = g_stage[NBLK-1].v_q;
  assign sum       = g_stage[NBLK-1].s_q;
  assign carry     = g_stage[NBLK-1].c_q;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

`ifdef CSA_OVERFLOW_FLAG_EN
  logic ov_n;
  logic ov_q;

  assign ov_n = (g_stage[NBLK-1].a_i[BLOCK-1] == g_stage[NBLK-1].b_i[BLOCK-1]) &
                (g_stage[NBLK-1].sel[BLOCK-1] != g_stage[NBLK-1].a_i[BLOCK-1]);

  // Signed overflow registered alongside the final segment so it matches sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
    end else if (adv) begin
      ov_q <= ov_n;
    end
  end

  assign overflow = ov_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Bench for pipelined_carry_select_adder (WIDTH=16, BLOCK=4, latency 4).
// Expected results come from plain a + b + cin arithmetic in the bench.
module tb_pipelined_carry_select_adder;

  localparam int W   = 16;
  localparam int LAT = 4;
`ifdef CSA_OVERFLOW_FLAG_EN
  localparam bit HAS_OV = 1'b1;
`else
  localparam bit HAS_OV = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         ov_obs;

  int checks   = 0;
  int failures = 0;

  pipelined_carry_select_adder #(.WIDTH(W), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
`ifdef CSA_OVERFLOW_FLAG_EN
    ,
    .overflow  (ov_obs)
`endif
  );

`ifndef CSA_OVERFLOW_FLAG_EN
  assign ov_obs = 1'b0;
`endif

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c, input logic r);
    in_valid  = v;
    a         = av;
    b         = bv;
    cin       = c;
    out_ready = r;
  endtask

  // Reference model: {overflow, carry, sum} of a + b + cin.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic c);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, c};
    ov   = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    return {HAS_OV & ov, full};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'hABCD, 16'h1234, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || sum !== 16'h0000 || carry !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d]: got valid=%b sum=%h carry=%b, want 0/0000/0",
                 i, out_valid, sum, carry);
      end
    end
  endtask

  task automatic test_single();
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < LAT - 1; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL single_early[%0d]: got valid=%b want 0", i, out_valid);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h0000 || carry !== 1'b1) begin
      failures++;
      $display("FAIL single_result: got valid=%b sum=%h carry=%b, want 1/0000/1",
               out_valid, sum, carry);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after: got valid=%b want 0", out_valid);
    end
  endtask

  // Issues one vector into an empty pipeline and checks latency and value.
  task automatic test_carry_in();
    logic [W-1:0] va[2] = '{16'h1234, 16'h0FFF};
    logic [W-1:0] vb[2] = '{16'h4321, 16'h0000};
    logic [W-1:0] es[2] = '{16'h5556, 16'h1000};
    int lat;
    for (int v = 0; v < 2; v++) begin
      drive(1'b1, va[v], vb[v], 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 12) begin
        tick();
        lat++;
      end
      checks++;
      if (lat != LAT || out_valid !== 1'b1 || sum !== es[v] || carry !== 1'b0) begin
        failures++;
        $display("FAIL carry_in[%0d]: got lat=%0d valid=%b sum=%h carry=%b, want %0d/1/%h/0",
                 v, lat, out_valid, sum, carry, LAT, es[v]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va[3]  = '{16'h0001, 16'h00FF, 16'h8000};
    logic [W-1:0] vb[3]  = '{16'h0001, 16'h0001, 16'h8000};
    logic [W:0]   exp[3] = '{17'h0_0002, 17'h0_0100, 17'h1_0000};
    int sent = 0;
    int got = 0;
    int stall = 0;
    bit stalled_once = 1'b0;
    logic [W:0] held = '0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (out_valid === 1'b1 && !stalled_once) begin
        stalled_once = 1'b1;
        stall = 2;
        held = {carry, sum};
      end
      if (sent < 3) drive(1'b1, va[sent], vb[sent], 1'b0, stall == 0);
      else          drive(1'b0, '0, '0, 1'b0, stall == 0);
      #1;
      if (stall > 0) begin
        checks++;
        if (in_ready !== 1'b0 || {carry, sum} !== held) begin
          failures++;
          $display("FAIL stall_hold: got in_ready=%b result=%h, want 0/%h",
                   in_ready, {carry, sum}, held);
        end
        stall--;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if ({carry, sum} !== exp[got]) begin
          failures++;
          $display("FAIL b2b_order[%0d]: got %h want %h", got, {carry, sum}, exp[got]);
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sent++;
      tick();
    end
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 3", got);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midflight();
    int lat;
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midflight_flush[%0d]: got valid=%b want 0", i, out_valid);
      end
      tick();
    end
    drive(1'b1, 16'h00F0, 16'h0F10, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != LAT || {carry, sum} !== 17'h0_1000) begin
      failures++;
      $display("FAIL midflight_after: got lat=%0d result=%h, want %0d/01000",
               lat, {carry, sum}, LAT);
    end
    tick();
  endtask

`ifdef CSA_OVERFLOW_FLAG_EN
  task automatic test_overflow();
    logic [W-1:0] va[2] = '{16'h7FFF, 16'hFFFF};
    logic [W-1:0] es[2] = '{16'h8000, 16'h0000};
    logic         eo[2] = '{1'b1, 1'b0};
    int lat;
    for (int v = 0; v < 2; v++) begin
      drive(1'b1, va[v], 16'h0001, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 12) begin
        tick();
        lat++;
      end
      checks++;
      if (lat != LAT || sum !== es[v] || ov_obs !== eo[v]) begin
        failures++;
        $display("FAIL overflow[%0d]: got lat=%0d sum=%h ov=%b, want %0d/%h/%b",
                 v, lat, sum, ov_obs, LAT, es[v], eo[v]);
      end
      tick();
    end
  endtask
`endif

  // Scoreboard run: random valid/ready, random and corner operands.
  task automatic test_random();
    logic [W+1:0] exp_q[$];
    logic [W+1:0] got;
    logic [W+1:0] prev = '0;
    logic [W+1:0] want;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit prev_stall = 1'b0;
    int sent = 0;
    int cyc = 0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      got = {ov_obs, carry, sum};
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || got !== prev) begin
          failures++;
          $display("FAIL rand_stall_hold: got valid=%b result=%h want 1/%h",
                   out_valid, got, prev);
        end
      end
      ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom_range(0, 16'hFFFF));
      rb = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom_range(0, 16'hFFFF));
      drive((sent < 1000) && ($urandom_range(0, 3) != 0), ra, rb,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected: got result=%h with no pending add", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL rand_result: got %h want %h", got, want);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(model(a, b, cin));
        sent++;
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev = got;
      tick();
      cyc++;
    end
    checks++;
    if (sent != 1000 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_drain: got sent=%0d pending=%0d want 1000/0", sent, exp_q.size());
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single();
    test_carry_in();
    test_back_to_back();
    test_reset_midflight();
`ifdef CSA_OVERFLOW_FLAG_EN
    test_overflow();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
